// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR burst arbiter.
// The helper maps the all-zero seed, which would lock up the LFSR, to a legal one.
package lfsr_pkg;

    localparam int DATA_W = 8;
    localparam int SEED_W = 7;
    localparam logic [SEED_W-1:0] DEFAULT_SEED = 7'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_GRANT = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    function automatic logic [SEED_W-1:0] safe_seed(input logic [SEED_W-1:0] s);
        return (s == '0) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first active request at or after
// the pointer (wrapping modulo NREQ) wins a one-hot grant.
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [PTR_W-1:0] ptr_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  gnt_o
);

    int   idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr_i) + off) % NREQ;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lfsr_arbiter.sv
// Shares one external LFSR/parity engine among NREQ requesters: round-robin
// burst grants, per-word handshake that steps the engine, and queued reseeds.
module lfsr_arbiter
    import lfsr_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    input  logic                  seed_load,
    input  logic [SEED_W-1:0]     seed_val,
    output logic                  lfsr_load,
    output logic [SEED_W-1:0]     lfsr_seed,
    output logic                  lfsr_step,
    input  logic [DATA_W-1:0]     lfsr_data,
    output logic                  busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t              state_q, state_d;
    logic                seed_pend_q, seed_pend_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;

    logic [NREQ-1:0]     arb_gnt;
    logic [PTR_W-1:0]    arb_idx;
    logic [LEN_W-1:0]    len_sel;
    logic [PTR_W-1:0]    ptr_after_win;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .ptr_i (ptr_q),
        .req_i (req),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        len_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = PTR_W'(i);
                len_sel = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign ptr_after_win = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);

    // The engine only advances on accepted words, so out_data holds through stalls.
    assign out_data  = lfsr_data;
    assign lfsr_seed = safe_seed(seed_q);
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        seed_pend_d = seed_pend_q;
        seed_d      = seed_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt         = '0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (seed_pend_q) begin
                    state_d = ST_LOAD;
                end else if (|req) begin
                    state_d = ST_GRANT;
                end
            end
            ST_LOAD: begin
                lfsr_load   = 1'b1;
                seed_pend_d = 1'b0;
                state_d     = ST_IDLE;
            end
            ST_GRANT: begin
                gnt = arb_gnt;
                if (|req) begin
                    win_d   = arb_idx;
                    cnt_d   = len_sel;
                    gnt_d   = arb_gnt;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                gnt       = gnt_q;
                out_valid = 1'b1;
                out_last  = (cnt_q == '0);
                if (out_ready) begin
                    lfsr_step = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        ptr_d   = ptr_after_win;
                        gnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end else if (!(|(req & gnt_q))) begin
                    // Requester withdrew mid-burst: abandon and move the pointer on.
                    state_d = ST_IDLE;
                    ptr_d   = ptr_after_win;
                    gnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new seed request wins over the LOAD-cycle clear so it is never lost.
        if (seed_load) begin
            seed_pend_d = 1'b1;
            seed_d      = seed_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            seed_pend_q <= 1'b1;
            seed_q      <= DEFAULT_SEED;
            ptr_q       <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            seed_pend_q <= seed_pend_d;
            seed_q      <= seed_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
        end
    end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter with a small behavioural LFSR engine model
// answering lfsr_load/lfsr_step; each scenario task checks its own outputs.
module tb_lfsr_arbiter;
    import lfsr_pkg::*;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DATA_W-1:0]     out_data;
    logic                  out_last;
    logic                  seed_load = 1'b0;
    logic [SEED_W-1:0]     seed_val = '0;
    logic                  lfsr_load;
    logic [SEED_W-1:0]     lfsr_seed;
    logic                  lfsr_step;
    logic [DATA_W-1:0]     lfsr_data;
    logic                  busy;

    int compared   = 0;
    int mismatched = 0;
    int step_cnt   = 0;
    int both_cnt   = 0;
    logic [6:0] eng = 7'h55;

    always #5 clk = ~clk;

    lfsr_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .lfsr_load (lfsr_load),
        .lfsr_seed (lfsr_seed),
        .lfsr_step (lfsr_step),
        .lfsr_data (lfsr_data),
        .busy      (busy)
    );

    // Engine model: x^7 + x^6 + 1 Fibonacci LFSR with even parity on top.
    always @(posedge clk) begin
        if (lfsr_load)      eng <= lfsr_seed;
        else if (lfsr_step) eng <= {eng[5:0], eng[6] ^ eng[5]};
        if (lfsr_step)              step_cnt <= step_cnt + 1;
        if (lfsr_load && lfsr_step) both_cnt <= both_cnt + 1;
    end
    assign lfsr_data = {^eng, eng};

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if ({busy, gnt, out_valid, out_last, lfsr_load, lfsr_step} !== 9'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got busy=%0b gnt=%b valid=%0b last=%0b load=%0b step=%0b, want all 0",
                     busy, gnt, out_valid, out_last, lfsr_load, lfsr_step);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (lfsr_load !== 1'b1 || lfsr_seed !== 7'h01 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_load: got load=%0b seed=%h busy=%0b, want 1 01 1", lfsr_load, lfsr_seed, busy);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || lfsr_load !== 1'b0 || eng !== 7'h01) begin
            mismatched++;
            $display("FAIL reset_idle: got busy=%0b load=%0b eng=%h, want 0 0 01", busy, lfsr_load, eng);
        end
        $display("reset: done");
    endtask

    task automatic test_single_burst();
        int s0;
        s0 = step_cnt;
        req = 4'b0001; req_len = '0; req_len[3:0] = 4'd3; out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== 4'b0001 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL single_grant: got gnt=%b valid=%0b, want 0001 0", gnt, out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 3) req = '0;
            #1;
            compared++;
            if (out_valid !== 1'b1 || out_data !== lfsr_data || out_last !== (k == 3) ||
                gnt !== 4'b0001 || lfsr_step !== 1'b1) begin
                mismatched++;
                $display("FAIL single_word%0d: got valid=%0b data=%h last=%0b gnt=%b step=%0b, want 1 %h %0b 0001 1",
                         k, out_valid, out_data, out_last, gnt, lfsr_step, lfsr_data, (k == 3));
            end
            $display("single: word %0d data=%h last=%0b", k, out_data, out_last);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || gnt !== 4'b0 || (step_cnt - s0) !== 4) begin
            mismatched++;
            $display("FAIL single_end: got busy=%0b gnt=%b steps=%0d, want 0 0000 4", busy, gnt, step_cnt - s0);
        end
    endtask

    task automatic test_round_robin();
        int k;
        logic [3:0] exp_g;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        req = 4'b1111; req_len = '0; out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            @(negedge clk);
            if (busy && !out_valid && !lfsr_load) begin
                exp_g = 4'b0001 << (k % 4);
                compared++;
                if (gnt !== exp_g) begin
                    mismatched++;
                    $display("FAIL rr_grant%0d: got gnt=%b, want %b", k, gnt, exp_g);
                end
                $display("rr: grant %0d gnt=%b", k, gnt);
                k++;
                if (k == 5) req = '0;
            end
        end
        compared++;
        if (k !== 5) begin
            mismatched++;
            $display("FAIL rr_timeout: got %0d grants, want 5", k);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int s0;
        logic [5:0] pat;
        logic [7:0] prev;
        pat = 6'b111001;
        s0 = step_cnt;
        req = 4'b0010; req_len = '0; req_len[7:4] = 4'd3; out_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (gnt !== 4'b0010) begin
            mismatched++;
            $display("FAIL stall_grant: got gnt=%b, want 0010", gnt);
        end
        prev = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = pat[c];
            if (c == 5) req = '0;
            #1;
            compared++;
            if (lfsr_step !== pat[c] || out_last !== (c == 5) ||
                (c > 0 && pat[c-1] == 1'b0 && out_data !== prev)) begin
                mismatched++;
                $display("FAIL stall_cyc%0d: got step=%0b last=%0b data=%h, want %0b %0b prev=%h",
                         c, lfsr_step, out_last, out_data, pat[c], (c == 5), prev);
            end
            $display("stall: cyc %0d ready=%0b data=%h step=%0b", c, out_ready, out_data, lfsr_step);
            prev = out_data;
        end
        @(negedge clk);
        out_ready = 1'b1;
        compared++;
        if (busy !== 1'b0 || (step_cnt - s0) !== 4) begin
            mismatched++;
            $display("FAIL stall_end: got busy=%0b steps=%0d, want 0 4", busy, step_cnt - s0);
        end
    endtask

    task automatic test_reseed_mid_burst();
        req = 4'b0100; req_len = '0; req_len[11:8] = 4'd3; out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== 4'b0100) begin
            mismatched++;
            $display("FAIL reseed_grant: got gnt=%b, want 0100", gnt);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seed_load = (k == 0);
            seed_val  = '0;
            #1;
            compared++;
            if (out_valid !== 1'b1 || out_last !== (k == 3) || lfsr_load !== 1'b0) begin
                mismatched++;
                $display("FAIL reseed_word%0d: got valid=%0b last=%0b load=%0b, want 1 %0b 0",
                         k, out_valid, out_last, lfsr_load, (k == 3));
            end
        end
        @(negedge clk);
        seed_load = 1'b0;
        @(negedge clk);
        compared++;
        if (lfsr_load !== 1'b1 || lfsr_seed !== 7'h01 || gnt !== 4'b0) begin
            mismatched++;
            $display("FAIL reseed_load: got load=%0b seed=%h gnt=%b, want 1 01 0000", lfsr_load, lfsr_seed, gnt);
        end
        $display("reseed: load seed=%h", lfsr_seed);
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (gnt !== 4'b0100 || eng !== 7'h01) begin
            mismatched++;
            $display("FAIL reseed_regrant: got gnt=%b eng=%h, want 0100 01", gnt, eng);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int s0;
        req = 4'b0001; req_len = '0; req_len[3:0] = 4'd7; out_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (gnt !== 4'b0001) begin
            mismatched++;
            $display("FAIL abort_grant: got gnt=%b, want 0001", gnt);
        end
        s0 = step_cnt;
        repeat (2) @(negedge clk);
        @(negedge clk);
        req = '0; out_ready = 1'b0;
        #1;
        compared++;
        if (lfsr_step !== 1'b0 || out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_drop: got step=%0b valid=%0b, want 0 1", lfsr_step, out_valid);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || gnt !== 4'b0 || (step_cnt - s0) !== 2) begin
            mismatched++;
            $display("FAIL abort_idle: got busy=%0b gnt=%b steps=%0d, want 0 0000 2", busy, gnt, step_cnt - s0);
        end
        req = 4'b0011;
        @(negedge clk);
        compared++;
        if (gnt !== 4'b0010) begin
            mismatched++;
            $display("FAIL abort_next: got gnt=%b, want 0010", gnt);
        end
        $display("abort: next grant gnt=%b", gnt);
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        req = 4'b1000; req_len = '0; req_len[15:12] = 4'd7; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if ({gnt, out_valid, busy, lfsr_step} !== 7'b0) begin
            mismatched++;
            $display("FAIL midreset_clear: got gnt=%b valid=%0b busy=%0b step=%0b, want all 0",
                     gnt, out_valid, busy, lfsr_step);
        end
        @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        compared++;
        if (lfsr_load !== 1'b1 || lfsr_seed !== 7'h01) begin
            mismatched++;
            $display("FAIL midreset_load: got load=%0b seed=%h, want 1 01", lfsr_load, lfsr_seed);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_idle: got busy=%0b, want 0", busy);
        end
        $display("midreset: done");
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_reseed_mid_burst();
        test_abort();
        test_mid_reset();
        compared++;
        if (both_cnt !== 0) begin
            mismatched++;
            $display("FAIL load_and_step: got %0d overlapping cycles, want 0", both_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
